apb_slave_mem: RTL
==================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter: DEPTH, 32, number of 32-bit words; word index = PADDR[7:2]; legal range 1..64.
REQ-002 SHALL have parameter: WAIT_STATES, 0, number of PREADY-low cycles inserted in each access phase; legal range 0..7.
REQ-003 SHALL have port: PCLK  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port: PRESET  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port: PSEL  input  1  slave select.
REQ-006 SHALL have port: PENABLE  input  1  access-phase indicator.
REQ-007 SHALL have port: PWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: PADDR  input  8  byte address.
REQ-009 SHALL have port: PWDATA  input  32  write data.
REQ-010 SHALL have port: PSTRB  input  4  byte-lane write strobes; PSTRB[i] covers PWDATA[8i+7:8i].
REQ-011 SHALL have port: PREADY  output  1  transfer completes in this cycle.
REQ-012 SHALL have port: PRDATA  output  32  read data; valid only while PREADY=1 on a read.
REQ-013 SHALL have port: PSLVERR  output  1  error response; valid only while PREADY=1.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, ACCESS and a 3-bit wait counter.
REQ-015 In IDLE, PSEL=1 with PENABLE=0 (setup phase) SHALL move the FSM to ACCESS, load the counter with WAIT_STATES, and latch PADDR, PWRITE, PWDATA and PSTRB.
REQ-016 In IDLE, PSEL=1 with PENABLE=1 (no setup phase) SHALL be ignored: the FSM stays in IDLE and PREADY stays 0.
REQ-017 In ACCESS with counter != 0, the counter SHALL decrement each cycle and PREADY SHALL be 0.
REQ-018 In ACCESS with counter == 0, PREADY SHALL be 1, decoded from registered state only with no combinational path from inputs.
REQ-019 Completion SHALL occur in a cycle where PSEL=1, PENABLE=1 and PREADY=1; the FSM then returns to IDLE on the next edge.
REQ-020 Latency SHALL be WAIT_STATES+1 cycles from the first ACCESS cycle to PREADY=1 inclusive; WAIT_STATES=0 gives PREADY=1 in the first access cycle.
REQ-021 Back-to-back transfers SHALL be supported: a new setup phase in the cycle after completion is accepted.
REQ-022 If PSEL drops while in ACCESS, the FSM SHALL abort to IDLE without writing and without asserting PREADY.
REQ-023 An address SHALL be in error if PADDR[1:0] != 0 or PADDR[7:2] >= DEPTH.
REQ-024 On an error access, PSLVERR SHALL be 1 during the PREADY cycle, memory SHALL be unchanged, and PRDATA SHALL be 0.
REQ-025 A good write SHALL update memory on the completion edge, per byte lane as set by PSTRB (see REQ-030).
REQ-026 A good read SHALL drive PRDATA = mem[PADDR[7:2]] during the PREADY cycle, and 0 in all other cycles.
REQ-027 PSLVERR SHALL be 0 in every cycle where PREADY=0.

Reset
REQ-028 While PRESET=1, outputs SHALL be PREADY=0, PSLVERR=0, PRDATA=0, with FSM=IDLE, counter=0 and all memory words 0.
REQ-029 Reset assertion mid-transfer SHALL abort immediately with no memory write; after release, the first accepted event SHALL be a fresh setup phase.

Configuration
REQ-030 Macro APB_SLV_STRB_EN:
- defined: only byte lanes with PSTRB[i]=1 are written; a write with PSTRB=4'b0000 completes normally and changes nothing.
- undefined: PSTRB is ignored and all four lanes are written on every good write.

Verification
REQ-031 WAIT_STATES=0: write 0xDEADBEEF to 0x04, then read 0x04 -> PREADY high in the first access cycle of each transfer, read PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-032 WAIT_STATES=3: read 0x00 after reset -> PREADY low for 3 access cycles, high on the 4th, PRDATA=0x00000000.
REQ-033 APB_SLV_STRB_EN defined: write 0x11223344 to 0x08 with PSTRB=4'b1111, then 0xAABBCCDD with PSTRB=4'b0101, then read 0x08 -> 0x11BB33DD. With the macro undefined, the same sequence reads 0xAABBCCDD.
REQ-034 DEPTH=32: write to 0x82, then to 0x80 -> PSLVERR=1 for both, and reads of all 32 words are unchanged.
REQ-035 WAIT_STATES=2: drop PSEL in the 2nd access cycle of a write to 0x10 -> no PREADY pulse, following read of 0x10 returns the old value.
REQ-036 Assert PRESET during the wait phase of a write to 0x0C -> outputs go to 0 asynchronously, a later read of 0x0C returns 0x00000000.

Source files
------------

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB register-file slave with wait states and address error response
// Optional byte-lane write strobes are enabled by defining APB_SLV_STRB_EN.
module apb_slave_mem #(
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   input  logic [3:0]  PSTRB,
   output logic        PREADY,
   output logic        PSLVERR,
   output logic [31:0] PRDATA
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n;
   logic        load, complete;
   logic [7:0]  addr;
   logic        wr;
   logic [31:0] wdata;
   logic [3:0]  lanes;
   logic [5:0]  idx;
   logic        err;
   logic [31:0] mem [64];

   assign idx = addr[7:2];
   assign err = (addr[1:0] != 2'b00) || ({26'd0, idx} >= DEPTH);

`ifdef APB_SLV_STRB_EN
   logic [3:0] strb;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         strb <= 4'h0;
      else if (load)
         strb <= PSTRB;
   end

   assign lanes = strb;
`else
   logic unused_strb;

   assign unused_strb = ^PSTRB;
   assign lanes       = 4'hF;
`endif

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state <= IDLE;
         cnt   <= 3'd0;
         addr  <= 8'h00;
         wr    <= 1'b0;
         wdata <= 32'h0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load) begin
            addr  <= PADDR;
            wr    <= PWRITE;
            wdata <= PWDATA;
         end
      end
   end

   // Outputs depend only on registered state, so PREADY has no path from the bus inputs.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      load     = 1'b0;
      complete = 1'b0;
      PREADY   = (state == ACCESS) && (cnt == 3'd0);
      PSLVERR  = PREADY && err;
      PRDATA   = (PREADY && !wr && !err) ? mem[idx] : 32'h0;
      case (state)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_n = ACCESS;
               cnt_n   = 3'(WAIT_STATES);
               load    = 1'b1;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_n = IDLE;
               cnt_n   = 3'd0;
            end else if (cnt != 3'd0) begin
               cnt_n = cnt - 3'd1;
            end else if (PENABLE) begin
               state_n  = IDLE;
               complete = 1'b1;
            end
         end
      endcase
   end

   // Words at or beyond DEPTH are never written, so they stay constant zero.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < 64; i++)
            mem[i] <= 32'h0;
      end else if (complete && wr && !err) begin
         for (int i = 0; i < 4; i++)
            if (lanes[i])
               mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

endmodule
